// File: rtl/picorv32_axil_pkg.sv
// Shared types and constants for the PicoRV32 native-memory to AXI4-Lite bridge.
package picorv32_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DONE,
    DRAIN
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_INSN = 3'b100;

endpackage

// File: rtl/picorv32_axil_bridge.sv
// Registered PicoRV32 native-memory to AXI4-Lite master, one transaction in flight,
// with error propagation and a response timeout that drains the late response.
module picorv32_axil_bridge
  import picorv32_axil_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  output logic              mem_axi_awvalid,
  input  logic              mem_axi_awready,
  output logic [ADDR_W-1:0] mem_axi_awaddr,
  output logic [2:0]        mem_axi_awprot,
  output logic              mem_axi_wvalid,
  input  logic              mem_axi_wready,
  output logic [DATA_W-1:0] mem_axi_wdata,
  output logic [STRB_W-1:0] mem_axi_wstrb,
  input  logic              mem_axi_bvalid,
  output logic              mem_axi_bready,
  input  logic [1:0]        mem_axi_bresp,
  output logic              mem_axi_arvalid,
  input  logic              mem_axi_arready,
  output logic [ADDR_W-1:0] mem_axi_araddr,
  output logic [2:0]        mem_axi_arprot,
  input  logic              mem_axi_rvalid,
  output logic              mem_axi_rready,
  input  logic [DATA_W-1:0] mem_axi_rdata,
  input  logic [1:0]        mem_axi_rresp
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              hold, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [2:0]        prot_q, prot_d;
  logic              is_write, is_write_d;
  logic              awvalid, awvalid_d, wvalid, wvalid_d, arvalid, arvalid_d;
  logic              bready, bready_d, rready, rready_d;
  logic              ready_q, ready_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, timeout_hit;

  assign aw_hs       = awvalid & mem_axi_awready;
  assign w_hs        = wvalid & mem_axi_wready;
  assign ar_hs       = arvalid & mem_axi_arready;
  assign b_hs        = bready & mem_axi_bvalid;
  assign r_hs        = rready & mem_axi_rvalid;
  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST);

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    hold_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    prot_d     = prot_q;
    is_write_d = is_write;
    awvalid_d  = awvalid & ~aw_hs;
    wvalid_d   = wvalid & ~w_hs;
    arvalid_d  = arvalid & ~ar_hs;
    bready_d   = bready;
    rready_d   = rready;
    ready_d    = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    unique case (state)
      IDLE: begin
        // hold masks the cycle right after a completion, while the core drops mem_valid
        if (mem_valid && !hold) begin
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wstrb_d    = mem_wstrb;
          prot_d     = mem_instr ? PROT_INSN : 3'b000;
          cnt_d      = '0;
          is_write_d = |mem_wstrb;
          if (|mem_wstrb) begin
            state_d   = WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = READ;
            arvalid_d = 1'b1;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt + CNT_W'(1);
        if (!awvalid_d && !wvalid_d) bready_d = 1'b1;
        if (b_hs) begin
          state_d  = DONE;
          bready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = (mem_axi_bresp != AXI_RESP_OKAY);
        end else if (timeout_hit) begin
          state_d  = DRAIN;
          bready_d = 1'b1;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
        end
      end
      READ: begin
        cnt_d = cnt + CNT_W'(1);
        if (!arvalid_d) rready_d = 1'b1;
        if (r_hs) begin
          state_d  = DONE;
          rready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = (mem_axi_rresp != AXI_RESP_OKAY);
          rdata_d  = mem_axi_rdata;
        end else if (timeout_hit) begin
          state_d  = DRAIN;
          rready_d = 1'b1;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        hold_d  = 1'b1;
      end
      DRAIN: begin
        if (is_write ? b_hs : r_hs) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          rready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      prot_q   <= '0;
      is_write <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      arvalid  <= 1'b0;
      bready   <= 1'b0;
      rready   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      hold     <= hold_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      prot_q   <= prot_d;
      is_write <= is_write_d;
      awvalid  <= awvalid_d;
      wvalid   <= wvalid_d;
      arvalid  <= arvalid_d;
      bready   <= bready_d;
      rready   <= rready_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // The completion pulse is withheld when the core abandoned its request mid-flight
  assign mem_ready       = ready_q & mem_valid;
  assign mem_rdata       = rdata_q;
  assign mem_err         = err_q;
  assign mem_axi_awvalid = awvalid;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready;
  assign mem_axi_arvalid = arvalid;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = prot_q;
  assign mem_axi_rready  = rready;

endmodule

// File: tb/tb_picorv32_axil_bridge.sv
// Scoreboard bench: core driver + memory-backed AXI-Lite slave, completions checked by a monitor.
module tb_picorv32_axil_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, mem_ready, mem_err;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready;
  logic        mem_axi_bvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_arready;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_rdata;
  logic [3:0]  mem_axi_wstrb;
  logic [2:0]  mem_axi_awprot, mem_axi_arprot;
  logic [1:0]  mem_axi_bresp, mem_axi_rresp;

  picorv32_axil_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_bresp(mem_axi_bresp),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .mem_axi_rresp(mem_axi_rresp)
  );

  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0, miscompares = 0, pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave knobs, fixed for the duration of one transaction
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0, force_resp = -1;
  bit b_early = 0;

  typedef struct { bit is_write; logic [31:0] rdata; bit err; } cpl_t;
  typedef struct { bit is_write; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot; } axi_t;
  cpl_t cpl_q[$];
  axi_t axi_q[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] slv_mem[int unsigned];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // responses: address bits [15:14] select OKAY/EXOKAY/SLVERR/DECERR unless forced
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (force_resp >= 0) return 2'(force_resp);
    return a[15:14];
  endfunction

  // unwritten words read back as an address-derived pattern
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a >> 2) ? slv_mem[a >> 2] : {a[15:0], ~a[15:0]};
  endfunction

  // reference model: one request in, one completion and one AXI transfer expected
  task automatic expect_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit instr, input bit tmo);
    cpl_t c;
    axi_t x;
    logic [1:0] rsp;
    rsp = resp_of(a);
    x = '{(s != 0), a, d, s, (instr ? 3'b100 : 3'b000)};
    c.is_write = (s != 0);
    c.err = tmo ? 1'b1 : (rsp != 2'b00);
    c.rdata = tmo ? 32'h0 : ref_rd(a);
    if (s != 0 && !tmo && rsp == 2'b00) ref_mem[a >> 2] = merge(ref_rd(a), d, s);
    axi_q.push_back(x);
    cpl_q.push_back(c);
  endtask

  task automatic do_req(input bit instr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit tmo, output int first_v, output int rdy_at);
    int unsigned c0;
    expect_req(a, d, s, instr, tmo);
    mem_valid = 1'b1; mem_instr = instr; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    c0 = cyc; first_v = -1; rdy_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (first_v < 0 && (mem_axi_awvalid | mem_axi_wvalid | mem_axi_arvalid)) first_v = int'(cyc - c0);
      if (mem_ready) begin rdy_at = int'(cyc - c0); break; end
    end
    check("req_completes", 64'(rdy_at >= 0), 64'd1);
    if (rdy_at < 0) cpl_q.delete();
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  // monitor: every completion pulse pops one expectation
  always @(negedge clk) begin : monitor
    cpl_t e;
    if (!rst && mem_ready) begin
      pulses++;
      if (cpl_q.size() == 0) check("spurious_ready", 64'd1, 64'd0);
      else begin
        e = cpl_q.pop_front();
        check("mem_err", 64'(mem_err), 64'(e.err));
        if (!e.is_write) check("mem_rdata", 64'(mem_rdata), 64'(e.rdata));
      end
    end
  end

  // AXI-Lite slave: drives at negedge; a handshake seen here completes at the next posedge
  bit have_aw, have_w, have_ar, wr_cmp, p_aw, p_w, p_ar, p_b, p_r;
  int aw_n, w_n, ar_n, b_n, r_n;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;

  always @(negedge clk) begin : slave
    axi_t x;
    if (rst) begin
      {have_aw, have_w, have_ar, wr_cmp, p_aw, p_w, p_ar, p_b, p_r} = '0;
      aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
      mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_arready = 0;
      mem_axi_bvalid = 0; mem_axi_rvalid = 0;
      mem_axi_bresp = 0; mem_axi_rresp = 0; mem_axi_rdata = 0;
    end else begin
      if (p_aw) have_aw = 1;
      if (p_w) have_w = 1;
      if (p_b) begin mem_axi_bvalid = 0; {have_aw, have_w, wr_cmp} = '0; aw_n = 0; w_n = 0; b_n = 0; end
      if (p_r) begin mem_axi_rvalid = 0; have_ar = 0; ar_n = 0; r_n = 0; end
      if (have_aw && have_w && !wr_cmp) begin
        wr_cmp = 1;
        if (axi_q.size() == 0 || !axi_q[0].is_write) check("axi_unexpected_write", 64'd1, 64'd0);
        else begin
          x = axi_q.pop_front();
          check("awaddr", 64'(cap_awaddr), 64'(x.addr));
          check("awprot", 64'(cap_awprot), 64'd0);
          check("wdata", 64'(cap_wdata), 64'(x.wdata));
          check("wstrb", 64'(cap_wstrb), 64'(x.strb));
        end
      end
      if (p_ar) begin
        have_ar = 1;
        if (axi_q.size() == 0 || axi_q[0].is_write) check("axi_unexpected_read", 64'd1, 64'd0);
        else begin
          x = axi_q.pop_front();
          check("araddr", 64'(cap_araddr), 64'(x.addr));
          check("arprot", 64'(cap_arprot), 64'(x.prot));
        end
      end
      if (mem_axi_awvalid && !have_aw) aw_n++;
      mem_axi_awready = mem_axi_awvalid && !have_aw && aw_n > aw_lat;
      if (mem_axi_wvalid && !have_w) w_n++;
      mem_axi_wready = mem_axi_wvalid && !have_w && w_n > w_lat;
      if (mem_axi_arvalid && !have_ar) ar_n++;
      mem_axi_arready = mem_axi_arvalid && !have_ar && ar_n > ar_lat;
      p_aw = mem_axi_awready; p_w = mem_axi_wready; p_ar = mem_axi_arready;
      if (p_aw) begin cap_awaddr = mem_axi_awaddr; cap_awprot = mem_axi_awprot; end
      if (p_w) begin cap_wdata = mem_axi_wdata; cap_wstrb = mem_axi_wstrb; end
      if (p_ar) begin cap_araddr = mem_axi_araddr; cap_arprot = mem_axi_arprot; end
      if (!mem_axi_bvalid && have_aw && (have_w || (b_early && p_w))) begin
        b_n++;
        if (b_n > b_lat) begin
          mem_axi_bvalid = 1;
          mem_axi_bresp = resp_of(cap_awaddr);
          if (mem_axi_bresp == 2'b00) slv_mem[cap_awaddr >> 2] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);
        end
      end
      if (!mem_axi_rvalid && have_ar) begin
        r_n++;
        if (r_n > r_lat) begin
          mem_axi_rvalid = 1;
          mem_axi_rdata = slv_rd(cap_araddr);
          mem_axi_rresp = resp_of(cap_araddr);
        end
      end
      p_b = mem_axi_bvalid && mem_axi_bready;
      p_r = mem_axi_rvalid && mem_axi_rready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fv, ra, p0;
    logic [31:0] a;
    logic [3:0] s;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", 64'({mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid, mem_axi_bready, mem_axi_rready}), 64'd0);
    check("rst_mem", 64'({mem_ready, mem_err, mem_rdata}), 64'd0);
    check("rst_addr", 64'({mem_axi_awaddr, mem_axi_wstrb, mem_axi_arprot}), 64'd0);
    rst = 1'b0;

    // immediate-ready write: valids at +1, completion at +3
    force_resp = 0;
    do_req(0, 32'h1000, 32'hDEADBEEF, 4'hF, 0, fv, ra);
    check("wr_valid_lat", 64'(fv), 64'd1);
    check("wr_ready_lat", 64'(ra), 64'd3);
    // back-to-back request is held off one cycle after completion
    do_req(0, 32'h1000, 32'h0, 4'h0, 0, fv, ra);
    check("holdoff_lat", 64'(fv), 64'd2);

    // instruction read, 5-cycle AR stall, SLVERR
    repeat (2) @(posedge clk);
    #1;
    ref_mem[32'h80 >> 2] = 32'h12345678;
    slv_mem[32'h80 >> 2] = 32'h12345678;
    force_resp = 2; ar_lat = 5;
    do_req(1, 32'h80, 32'h0, 4'h0, 0, fv, ra);
    force_resp = -1; ar_lat = 0;

    // W four cycles after AW, B raised together with wready
    repeat (2) @(posedge clk);
    #1;
    w_lat = 4; b_early = 1; p0 = pulses;
    do_req(0, 32'h0044, 32'hA5A55A5A, 4'h5, 0, fv, ra);
    repeat (4) @(posedge clk);
    #1;
    check("single_pulse", 64'(pulses - p0), 64'd1);
    w_lat = 0; b_early = 0;

    // silent slave: forced error at TIMEOUT, late response drained silently
    repeat (2) @(posedge clk);
    #1;
    r_lat = 28; p0 = pulses;
    do_req(0, 32'h0100, 32'h0, 4'h0, 1, fv, ra);
    check("timeout_lat", 64'(ra - fv), 64'(TMO));
    repeat (25) @(posedge clk);
    #1;
    check("drain_no_pulse", 64'(pulses - p0), 64'd1);
    check("drain_idle", 64'({mem_axi_rready, mem_axi_arvalid}), 64'd0);
    r_lat = 0;
    do_req(0, 32'h0100, 32'h0, 4'h0, 0, fv, ra);

    // core abandons a read: AXI completes, no pulse
    r_lat = 6; p0 = pulses;
    axi_q.push_back('{0, 32'h0200, 32'h0, 4'h0, 3'b000});
    mem_valid = 1; mem_instr = 0; mem_addr = 32'h0200; mem_wstrb = 0;
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    check("abandon_no_pulse", 64'(pulses - p0), 64'd0);
    r_lat = 0;

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 4); r_lat = $urandom_range(0, 4);
      a = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 7) << 2);
      s = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      do_req(1'($urandom_range(0, 1)), a, $urandom, s, 0, fv, ra);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end

    // reset mid-write drops valids at once
    aw_lat = 20; w_lat = 20;
    mem_valid = 1; mem_addr = 32'h0300; mem_wdata = 32'h1; mem_wstrb = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_awvalid", 64'({mem_axi_awvalid, mem_axi_wvalid}), 64'd3);
    rst = 1; mem_valid = 0;
    @(posedge clk);
    #1;
    check("mid_rst_valids", 64'({mem_axi_awvalid, mem_axi_wvalid, mem_ready}), 64'd0);
    rst = 0; axi_q.delete(); cpl_q.delete();
    aw_lat = 0; w_lat = 0;
    @(posedge clk);
    #1;
    do_req(0, 32'h0000, 32'h0, 4'h0, 0, fv, ra);

    repeat (5) @(posedge clk);
    check("queues_empty", 64'(cpl_q.size() + axi_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
